// File: rtl/key_debounce_pkg.sv
// Shared definitions for push-button input conditioning: channel state encoding,
// default timing constants and clock/millisecond helpers reused by other input blocks.
package key_debounce_pkg;

    typedef enum logic [1:0] {
        ST_UP      = 2'd0,
        ST_WAIT_DN = 2'd1,
        ST_DOWN    = 2'd2,
        ST_WAIT_UP = 2'd3
    } key_state_e;

    localparam int unsigned CLK_HZ        = 50_000_000;
    localparam int unsigned CYCLES_PER_MS = CLK_HZ / 1000;

    localparam int unsigned DEF_DEBOUNCE_CYCLES      = 10  * CYCLES_PER_MS;
    localparam int unsigned DEF_REPEAT_DELAY_CYCLES  = 500 * CYCLES_PER_MS;
    localparam int unsigned DEF_REPEAT_PERIOD_CYCLES = 100 * CYCLES_PER_MS;

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/key_debounce_channel.sv
// One push-button: 2-flop synchronizer, 4-state debounce FSM and pulse generation.
// Auto-repeat while held is built only when KEY_AUTOREPEAT_EN is defined.
module key_debounce_channel
    import key_debounce_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES      = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned REPEAT_DELAY_CYCLES  = DEF_REPEAT_DELAY_CYCLES,
    parameter int unsigned REPEAT_PERIOD_CYCLES = DEF_REPEAT_PERIOD_CYCLES
) (
    input  logic clk,
    input  logic reset_n,
    input  logic key_n_raw,
    output logic key_level,
    output logic key_press,
    output logic key_release
);

    localparam int unsigned CNT_MAX = max3(DEBOUNCE_CYCLES, REPEAT_DELAY_CYCLES,
                                           REPEAT_PERIOD_CYCLES);
    localparam int CNT_W = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] DEB_LIM = CNT_W'(DEBOUNCE_CYCLES);

    // Pin polarity kept through the synchronizer; reset value 1 reads as released.
    logic [1:0]       sync_q;
    logic             s;
    key_state_e       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             level_q;
    logic             press_q;
    logic             release_q;

    assign s = ~sync_q[1];

`ifdef KEY_AUTOREPEAT_EN
    localparam logic [CNT_W-1:0] RPT_FIRST = CNT_W'(REPEAT_DELAY_CYCLES - 1);
    localparam logic [CNT_W-1:0] RPT_NEXT  = CNT_W'(REPEAT_PERIOD_CYCLES - 1);
    logic [CNT_W-1:0] rpt_q;
    logic             rpt_periodic_q;
    logic [CNT_W-1:0] rpt_lim;
    assign rpt_lim = rpt_periodic_q ? RPT_NEXT : RPT_FIRST;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q    <= 2'b11;
            state_q   <= ST_UP;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
`ifdef KEY_AUTOREPEAT_EN
            rpt_q          <= '0;
            rpt_periodic_q <= 1'b0;
`endif
        end else begin
            sync_q    <= {sync_q[0], key_n_raw};
            press_q   <= 1'b0;
            release_q <= 1'b0;
            case (state_q)
                ST_UP: begin
                    if (s) begin
                        state_q <= ST_WAIT_DN;
                        cnt_q   <= CNT_W'(1);
                    end
                end
                ST_WAIT_DN: begin
                    if (!s) begin
                        state_q <= ST_UP;
                    end else if (cnt_q == DEB_LIM) begin
                        state_q <= ST_DOWN;
                        press_q <= 1'b1;
                        level_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_DOWN: begin
                    if (!s) begin
                        state_q <= ST_WAIT_UP;
                        cnt_q   <= CNT_W'(1);
                    end
`ifdef KEY_AUTOREPEAT_EN
                    // Repeat timer only advances while settled in DOWN; bounces freeze it.
                    else if (rpt_q == rpt_lim) begin
                        press_q        <= 1'b1;
                        rpt_q          <= '0;
                        rpt_periodic_q <= 1'b1;
                    end else begin
                        rpt_q <= rpt_q + CNT_W'(1);
                    end
`endif
                end
                ST_WAIT_UP: begin
                    if (s) begin
                        state_q <= ST_DOWN;
                    end else if (cnt_q == DEB_LIM) begin
                        state_q   <= ST_UP;
                        release_q <= 1'b1;
                        level_q   <= 1'b0;
`ifdef KEY_AUTOREPEAT_EN
                        rpt_q          <= '0;
                        rpt_periodic_q <= 1'b0;
`endif
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: state_q <= ST_UP;
            endcase
        end
    end

    assign key_level   = level_q;
    assign key_press   = press_q;
    assign key_release = release_q;

endmodule

// File: rtl/key_debounce.sv
// Debounces NUM_KEYS active-low push-buttons into levels and press/release pulses.
// Define KEY_AUTOREPEAT_EN to get periodic key_press pulses while a key is held.
module key_debounce
    import key_debounce_pkg::*;
#(
    parameter int unsigned NUM_KEYS             = 4,
    parameter int unsigned DEBOUNCE_CYCLES      = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned REPEAT_DELAY_CYCLES  = DEF_REPEAT_DELAY_CYCLES,
    parameter int unsigned REPEAT_PERIOD_CYCLES = DEF_REPEAT_PERIOD_CYCLES
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [NUM_KEYS-1:0] key_n_raw,
    output logic [NUM_KEYS-1:0] key_level,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release,
    output logic                any_press
);

    generate
        for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_chan
            key_debounce_channel #(
                .DEBOUNCE_CYCLES     (DEBOUNCE_CYCLES),
                .REPEAT_DELAY_CYCLES (REPEAT_DELAY_CYCLES),
                .REPEAT_PERIOD_CYCLES(REPEAT_PERIOD_CYCLES)
            ) u_chan (
                .clk        (clk),
                .reset_n    (reset_n),
                .key_n_raw  (key_n_raw[gi]),
                .key_level  (key_level[gi]),
                .key_press  (key_press[gi]),
                .key_release(key_release[gi])
            );
        end
    endgenerate

    // OR of flop outputs, so it changes in the same cycle as key_press.
    assign any_press = |key_press;

endmodule
